dma_req_arbiter: RTL

Parametrised DMA request/priority arbiter and bus-handshake controller for the DMA subsystem, generalising the fixed 4-channel 8237-style DREQ/DACK/HRQ/HLDA scheme to NCH channels. It synchronises peripheral requests, applies per-channel masks and fixed or rotating priority, and runs the HRQ/HLDA handshake with the CPU. It grants exactly one channel a DACK per service period. It sits between the peripheral request lines and the DMA transfer engine, which supplies terminal count.

---
 rtl/dma_req_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/dma_req_arbiter.sv
// dma_req_arbiter
//   NCH-channel DMA request arbiter with an HRQ/HLDA bus-handshake controller.
//   Requests are synchronised, masked and arbitrated with fixed priority
//   (channel 0 highest) or rotating priority. One channel per service period
//   is granted a DACK.
// Ports:
//   CLK, RESET       rising-edge clock, synchronous active-high reset
//   DREQ, DREQ_POL   asynchronous channel requests and their polarity (1 = active-low)
//   DACK_POL         DACK polarity (1 = active-high)
//   ROT_PRI          0 = fixed priority, 1 = rotating priority
//   MASK_WR/DATA     mask register load (1 = channel masked)
//   HLDA, TC         hold acknowledge from the CPU, terminal-count pulse from the engine
//   HRQ              hold request to the CPU
//   DACK             channel acknowledges
//   ACT_VLD, ACT_CH  granted-channel valid flag and index
//   MASK             mask register readback
module dma_req_arbiter #(
  parameter int NCH = 4,
  parameter int CHW = $clog2(NCH)
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic [NCH-1:0] DREQ,
  input  logic           DREQ_POL,
  input  logic           DACK_POL,
  input  logic           ROT_PRI,
  input  logic           MASK_WR,
  input  logic [NCH-1:0] MASK_DATA,
  input  logic           HLDA,
  input  logic           TC,
  output logic           HRQ,
  output logic [NCH-1:0] DACK,
  output logic           ACT_VLD,
  output logic [CHW-1:0] ACT_CH,
  output logic [NCH-1:0] MASK
);

  localparam int unsigned N = NCH;

  typedef enum logic [1:0] {IDLE, REQ, SVC} state_t;

  state_t         state_q, state_d;
  logic [NCH-1:0] sync1_q, sync2_q;
  logic [NCH-1:0] mask_q, mask_d;
  logic [NCH-1:0] dack_raw_q, dack_raw_d;
  logic [CHW-1:0] ptr_q, ptr_d;
  logic [CHW-1:0] act_ch_q, act_ch_d;
  logic           act_vld_q, act_vld_d;
  logic           hrq_q, hrq_d;

  logic [NCH-1:0] req_eff;
  logic [CHW-1:0] base;
  logic [CHW-1:0] win_ch;
  logic           win_vld;
  logic [CHW-1:0] ptr_after;

  assign req_eff = (sync2_q ^ {NCH{DREQ_POL}}) & ~mask_q;

  // Search starts at the rotation pointer and wraps; fixed mode searches from 0.
  always_comb begin
    int unsigned idx;
    base    = ROT_PRI ? ptr_q : '0;
    win_vld = 1'b0;
    win_ch  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = 32'(base) + i;
      if (idx >= N) idx = idx - N;
      if (!win_vld && req_eff[idx]) begin
        win_vld = 1'b1;
        win_ch  = CHW'(idx);
      end
    end
  end

  // Serviced channel becomes lowest priority.
  assign ptr_after = (act_ch_q == CHW'(NCH - 1)) ? '0 : act_ch_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    dack_raw_d = dack_raw_q;
    ptr_d      = ROT_PRI ? ptr_q : '0;
    act_ch_d   = act_ch_q;
    act_vld_d  = act_vld_q;
    hrq_d      = hrq_q;
    unique case (state_q)
      IDLE: begin
        if (|req_eff && !HLDA) begin
          state_d = REQ;
          hrq_d   = 1'b1;
        end
      end
      REQ: begin
        if (!(|req_eff)) begin
          state_d = IDLE;
          hrq_d   = 1'b0;
        end else if (HLDA && win_vld) begin
          state_d            = SVC;
          act_ch_d           = win_ch;
          act_vld_d          = 1'b1;
          dack_raw_d         = '0;
          dack_raw_d[win_ch] = 1'b1;
        end
      end
      SVC: begin
        if (TC || !req_eff[act_ch_q] || !HLDA) begin
          state_d    = IDLE;
          hrq_d      = 1'b0;
          act_vld_d  = 1'b0;
          dack_raw_d = '0;
          if (ROT_PRI) ptr_d = ptr_after;
          if (TC) mask_d[act_ch_q] = 1'b1;
        end
      end
      default: begin
        state_d    = IDLE;
        hrq_d      = 1'b0;
        act_vld_d  = 1'b0;
        dack_raw_d = '0;
      end
    endcase
    // Explicit mask write overrides a same-cycle terminal-count auto-mask.
    if (MASK_WR) mask_d = MASK_DATA;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      sync1_q    <= '0;
      sync2_q    <= '0;
      mask_q     <= '1;
      dack_raw_q <= '0;
      ptr_q      <= '0;
      act_ch_q   <= '0;
      act_vld_q  <= 1'b0;
      hrq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= DREQ;
      sync2_q    <= sync1_q;
      mask_q     <= mask_d;
      dack_raw_q <= dack_raw_d;
      ptr_q      <= ptr_d;
      act_ch_q   <= act_ch_d;
      act_vld_q  <= act_vld_d;
      hrq_q      <= hrq_d;
    end
  end

  assign HRQ     = hrq_q;
  assign ACT_VLD = act_vld_q;
  assign ACT_CH  = act_ch_q;
  assign MASK    = mask_q;
  assign DACK    = dack_raw_q ^ {NCH{~DACK_POL}};

endmodule
